// File: rtl/muldiv_iter_if.sv
// Command/result bundle for the iterative multiply/divide unit.
// DivZero exists only when MULDIV_DIVZERO_EN is defined.
interface muldiv_iter_if #(parameter int WIDTH = 32);
  logic             Kill;
  logic             MultOp;
  logic             DivOp;
  logic             SignedOp;
  logic             StoreHiLo;
  logic             HiLoSel;
  logic             LoadHiLo;
  logic [WIDTH-1:0] Src1;
  logic [WIDTH-1:0] Src2;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             HLNotReady;
  logic             Done;
`ifdef MULDIV_DIVZERO_EN
  logic             DivZero;
`endif

  modport master (
    output Kill, MultOp, DivOp, SignedOp, StoreHiLo, HiLoSel, LoadHiLo, Src1, Src2,
`ifdef MULDIV_DIVZERO_EN
    input  DivZero,
`endif
    input  Hi, Lo, Busy, HLNotReady, Done
  );

  modport slave (
    input  Kill, MultOp, DivOp, SignedOp, StoreHiLo, HiLoSel, LoadHiLo, Src1, Src2,
`ifdef MULDIV_DIVZERO_EN
    output DivZero,
`endif
    output Hi, Lo, Busy, HLNotReady, Done
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide with Hi/Lo registers and load interlock.
// Optional DivZero flag enabled by MULDIV_DIVZERO_EN.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic          Clk,
  input  logic          ResetBAR,
  muldiv_iter_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   a_raw;
  logic               sign_a, sign_b, is_div, div0;
  logic [WIDTH-1:0]   hi, lo;
  logic               done;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  logic             sa, sb;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] hi_res, lo_res;

  always_comb begin
    sa       = bus.SignedOp & bus.Src1[WIDTH-1];
    sb       = bus.SignedOp & bus.Src2[WIDTH-1];
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b : {WIDTH{1'b0}})};
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b};
  end

  // Sign correction applied on the FIX cycle; divide-by-zero bypasses the datapath.
  always_comb begin
    hi_res = '0;
    lo_res = '0;
    if (!is_div) begin
      {hi_res, lo_res} = (sign_a ^ sign_b) ? -acc : acc;
    end else if (div0) begin
      hi_res = a_raw;
      lo_res = '1;
    end else begin
      lo_res = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      hi_res = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

`ifdef MULDIV_DIVZERO_EN
  logic divzero;
  always_ff @(posedge Clk or negedge ResetBAR) begin
    if (!ResetBAR) begin
      divzero <= 1'b0;
    end else if (!bus.Kill && (bus.MultOp || bus.DivOp || bus.StoreHiLo)) begin
      divzero <= 1'b0;
    end else if (state == FIX && is_div && div0) begin
      divzero <= 1'b1;
    end
  end
  assign bus.DivZero = divzero;
`endif

  always_ff @(posedge Clk or negedge ResetBAR) begin
    if (!ResetBAR) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      b      <= '0;
      a_raw  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.Kill) begin
        state <= IDLE;
      end else if (bus.MultOp || bus.DivOp) begin
        // A start while busy simply overwrites the in-flight operation.
        state  <= bus.MultOp ? MUL : DIV;
        is_div <= !bus.MultOp;
        cnt    <= CNT_W'(WIDTH);
        sign_a <= sa;
        sign_b <= sb;
        a_raw  <= bus.Src1;
        div0   <= !bus.MultOp && (bus.Src2 == '0);
        if (bus.MultOp) begin
          acc <= {{WIDTH{1'b0}}, mag(bus.Src2, sb)};
          b   <= mag(bus.Src1, sa);
        end else begin
          acc <= {{WIDTH{1'b0}}, mag(bus.Src1, sa)};
          b   <= mag(bus.Src2, sb);
        end
      end else if (bus.StoreHiLo) begin
        state <= IDLE;
        if (bus.HiLoSel) hi <= bus.Src2;
        else             lo <= bus.Src2;
      end else begin
        case (state)
          MUL: begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= FIX;
          end
          DIV: begin
            if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc <= {acc[2*WIDTH-2:0], 1'b0};
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= FIX;
          end
          FIX: begin
            hi    <= hi_res;
            lo    <= lo_res;
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.Hi         = hi;
  assign bus.Lo         = lo;
  assign bus.Busy       = (state != IDLE);
  assign bus.HLNotReady = bus.LoadHiLo & (state != IDLE);
  assign bus.Done       = done;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter at WIDTH=32.
module tb_muldiv_iter;
  logic Clk = 1'b0;
  logic ResetBAR = 1'b0;
  int checks = 0;
  int errors = 0;

  muldiv_iter_if #(.WIDTH(32)) bus ();
  muldiv_iter #(.WIDTH(32)) dut (.Clk(Clk), .ResetBAR(ResetBAR), .bus(bus));

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.Kill = 0; bus.MultOp = 0; bus.DivOp = 0; bus.SignedOp = 0;
    bus.StoreHiLo = 0; bus.HiLoSel = 0; bus.LoadHiLo = 0; bus.Src1 = '0; bus.Src2 = '0;
  endtask

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic store(input logic sel, input logic [31:0] v);
    bus.StoreHiLo = 1; bus.HiLoSel = sel; bus.Src2 = v;
    step();
    bus.StoreHiLo = 0;
  endtask

  // Issue an op and watch 40 edges; edge 1 is the start edge.
  task automatic run_op(input logic m, input logic d, input logic s,
                        input logic [31:0] a, input logic [31:0] bb,
                        output int dedge, output int bcnt, output int dcnt);
    bus.MultOp = m; bus.DivOp = d; bus.SignedOp = s; bus.Src1 = a; bus.Src2 = bb;
    dedge = -1; bcnt = 0; dcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1) begin bus.MultOp = 0; bus.DivOp = 0; end
      if (bus.Busy) bcnt++;
      if (bus.Done) begin
        dcnt++;
        if (dedge < 0) dedge = i;
      end
    end
  endtask

  int de, bc, dc, mism;

  initial begin
    idle_inputs();
    #12;
    chk("reset_hi", bus.Hi, 0);
    chk("reset_lo", bus.Lo, 0);
    chk("reset_busy", bus.Busy, 0);
    chk("reset_done", bus.Done, 0);
    ResetBAR = 1;
    step();

    // Reset mid-multiply clears a previously stored Lo
    store(1'b0, 32'hAA);
    chk("store_lo", bus.Lo, 32'hAA);
    bus.MultOp = 1; bus.Src1 = 3; bus.Src2 = 4;
    step();
    bus.MultOp = 0;
    repeat (9) step();
    chk("busy_mid_mul", bus.Busy, 1);
    ResetBAR = 0;
    #2;
    chk("rst_mid_lo", bus.Lo, 0);
    chk("rst_mid_busy", bus.Busy, 0);
    chk("rst_mid_done", bus.Done, 0);
    step();
    ResetBAR = 1;
    step();

    store(1'b1, 32'h5);
    chk("store_hi", bus.Hi, 32'h5);
    chk("store_busy", bus.Busy, 0);

    run_op(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, de, bc, dc);
    chk("umul_done_edge", de, 34);
    chk("umul_busy_cycles", bc, 33);
    chk("umul_done_pulses", dc, 1);
    chk("umul_hi", bus.Hi, 32'hFFFFFFFE);
    chk("umul_lo", bus.Lo, 32'h1);

    run_op(0, 1, 1, 32'hFFFFFFF9, 32'h2, de, bc, dc);
    chk("sdiv_lo", bus.Lo, 32'hFFFFFFFD);
    chk("sdiv_hi", bus.Hi, 32'hFFFFFFFF);
    chk("sdiv_done_edge", de, 34);

    run_op(0, 1, 1, 32'h7, 32'hFFFFFFFE, de, bc, dc);
    chk("sdiv2_lo", bus.Lo, 32'hFFFFFFFD);
    chk("sdiv2_hi", bus.Hi, 32'h1);

    run_op(1, 0, 1, 32'hFFFFFFFD, 32'h5, de, bc, dc);
    chk("smul_hi", bus.Hi, 32'hFFFFFFFF);
    chk("smul_lo", bus.Lo, 32'hFFFFFFF1);

    run_op(0, 1, 0, 32'h1234, 32'h0, de, bc, dc);
    chk("div0_lo", bus.Lo, 32'hFFFFFFFF);
    chk("div0_hi", bus.Hi, 32'h1234);
    chk("div0_busy_cycles", bc, 33);
`ifdef MULDIV_DIVZERO_EN
    chk("div0_flag", bus.DivZero, 1);
`endif
    run_op(1, 0, 0, 32'h2, 32'h3, de, bc, dc);
    chk("mul_after_div0_lo", bus.Lo, 32'h6);
    chk("mul_after_div0_hi", bus.Hi, 32'h0);
`ifdef MULDIV_DIVZERO_EN
    chk("div0_flag_cleared", bus.DivZero, 0);
`endif

    run_op(0, 1, 1, 32'h80000000, 32'hFFFFFFFF, de, bc, dc);
    chk("min_div_lo", bus.Lo, 32'h80000000);
    chk("min_div_hi", bus.Hi, 32'h0);

    // Kill at cycle 10 of a multiply with LoadHiLo held throughout
    bus.MultOp = 1; bus.Src1 = 7; bus.Src2 = 7; bus.LoadHiLo = 1;
    mism = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) bus.MultOp = 0;
      if (bus.HLNotReady !== 1'b1) mism++;
    end
    chk("hlnr_while_busy", mism, 0);
    bus.Kill = 1;
    step();
    bus.Kill = 0;
    chk("kill_busy", bus.Busy, 0);
    chk("kill_hlnr", bus.HLNotReady, 0);
    chk("kill_lo", bus.Lo, 32'h80000000);
    chk("kill_hi", bus.Hi, 32'h0);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.Done) dc++;
    end
    chk("kill_no_done", dc, 0);
    chk("kill_lo_later", bus.Lo, 32'h80000000);
    bus.LoadHiLo = 0;

    // Kill in the same cycle as a start
    bus.Kill = 1; bus.MultOp = 1; bus.Src1 = 9; bus.Src2 = 9;
    step();
    bus.Kill = 0; bus.MultOp = 0;
    chk("kill_start_busy", bus.Busy, 0);

    // DivOp 100/7 issued at cycle 5 of a running multiply
    bus.MultOp = 1; bus.Src1 = 5; bus.Src2 = 5;
    step();
    bus.MultOp = 0;
    repeat (4) step();
    run_op(0, 1, 0, 32'd100, 32'd7, de, bc, dc);
    chk("restart_done_edge", de, 34);
    chk("restart_done_pulses", dc, 1);
    chk("restart_lo", bus.Lo, 32'd14);
    chk("restart_hi", bus.Hi, 32'd2);

    // Store while busy aborts the op and still writes
    bus.MultOp = 1; bus.Src1 = 6; bus.Src2 = 6;
    step();
    bus.MultOp = 0;
    repeat (2) step();
    store(1'b0, 32'h77);
    chk("store_busy_abort", bus.Busy, 0);
    chk("store_busy_lo", bus.Lo, 32'h77);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.Done) dc++;
    end
    chk("store_abort_no_done", dc, 0);
    chk("store_abort_hi", bus.Hi, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
